// File: rtl/adder_check_pkg.sv
// adder_check_pkg: shared types and constants for the adder result checker.
//   state_e  - checker FSM states
//   CNT_W    - width of the pass/fail counters, vector count and vector index
//   sat_inc  - saturating increment for the result counters
package adder_check_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adder_ref_pipe.sv
// adder_ref_pipe: reference adder plus a LATENCY-deep expected/valid/tag delay
// line, so each expectation pops out in the same cycle as the adder's result.
//   clk, rst_n         - clock, synchronous active-low reset
//   flush_i            - clears every valid bit (new run)
//   push_i             - load a new expectation from a_i/b_i/cin_i
//   a_i, b_i, cin_i    - operands applied to the adder under test
//   tag_i / tag_o      - opaque side payload carried alongside the expectation
//   out_valid_o        - exit stage holds a live expectation this cycle
//   last_c_o           - exit stage is the only live expectation in the line
//   exp_o              - expected {cout, sum} at the exit stage
module adder_ref_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TAG_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  output logic             last_c_o,
  output logic [WIDTH:0]   exp_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [LATENCY-1:0] EXIT_ONLY = LATENCY'(1) << (LATENCY - 1);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [EW-1:0]      exp_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [EW-1:0]      exp_c;

  // Computed one bit wider so the carry-out lands in the MSB
  assign exp_c = EW'(a_i) + EW'(b_i) + EW'(cin_i);

  // Valid bits shift toward the exit stage
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = push_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload only matters where its valid bit is set, so it needs no reset
  always_ff @(posedge clk) begin
    exp_q[0] <= exp_c;
    tag_q[0] <= tag_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      exp_q[i] <= exp_q[i-1];
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign last_c_o    = (valid_q == EXIT_ONLY);
  assign exp_o       = exp_q[LATENCY-1];
  assign tag_o       = tag_q[LATENCY-1];

endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: runs num_vec vectors through an external adder,
// compares each {cout,sum} against a delayed reference and counts results.
//   clk, rst_n              - clock, synchronous active-low reset
//   start, num_vec          - begin a run of num_vec vectors (IDLE/DONE only)
//   in_valid, a, b, cin     - vector applied to the adder this cycle
//   sum, cout               - adder result, LATENCY cycles after its operands
//   busy, done              - run in progress / run finished
//   pass_cnt, fail_cnt      - saturating compare counters for this run
//   error                   - sticky mismatch flag for this run
// Optional macro ADDER_CHECK_FIRST_FAIL_EN adds ff_a, ff_b, ff_cin, ff_idx:
// operands and 0-based index of the first mismatching vector of the run.
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error
`ifdef ADDER_CHECK_FIRST_FAIL_EN
  ,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_cin,
  output logic [CNT_W-1:0] ff_idx
`endif
);

`ifdef ADDER_CHECK_FIRST_FAIL_EN
  localparam int unsigned TAG_W = 2 * WIDTH + 1 + CNT_W;
`else
  localparam int unsigned TAG_W = 1;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_ok_c;
  logic             accept_c;
  logic             pipe_valid;
  logic             pipe_last;
  logic [WIDTH:0]   pipe_exp;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;

`ifdef ADDER_CHECK_FIRST_FAIL_EN
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic             ff_cin_q, ff_cin_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;

  // Operands and vector index ride along so they are at hand at compare time
  assign tag_in = {a, b, cin, acc_q};
`else
  logic unused_tag;

  assign tag_in     = 1'b0;
  assign unused_tag = ^tag_out;
`endif

  adder_ref_pipe #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY),
    .TAG_W  (TAG_W)
  ) u_ref_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (start_ok_c),
    .push_i     (accept_c),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .tag_i      (tag_in),
    .out_valid_o(pipe_valid),
    .last_c_o   (pipe_last),
    .exp_o      (pipe_exp),
    .tag_o      (tag_out)
  );

  // Next-state, counter and capture logic
  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    acc_d      = acc_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    error_d    = error_q;
    start_ok_c = 1'b0;
    accept_c   = 1'b0;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_cin_d   = ff_cin_q;
    ff_idx_d   = ff_idx_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_d    = (num_vec == '0) ? ST_DONE : ST_RUN;
          num_vec_d  = num_vec;
          acc_d      = '0;
          pass_d     = '0;
          fail_d     = '0;
          error_d    = 1'b0;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
          ff_a_d     = '0;
          ff_b_d     = '0;
          ff_cin_d   = 1'b0;
          ff_idx_d   = '0;
`endif
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          accept_c = 1'b1;
          acc_d    = acc_q + CNT_W'(1);
          if (acc_d == num_vec_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing else is in flight once the final vector reaches the exit
        if (pipe_valid && pipe_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Oldest expectation meets the adder's result in this cycle
    if (pipe_valid) begin
      if ({cout, sum} == pipe_exp) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d  = sat_inc(fail_q);
        error_d = 1'b1;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
        if (!error_q) begin
          ff_a_d   = tag_out[TAG_W-1 -: WIDTH];
          ff_b_d   = tag_out[CNT_W+1 +: WIDTH];
          ff_cin_d = tag_out[CNT_W];
          ff_idx_d = tag_out[CNT_W-1:0];
        end
`endif
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_vec_q <= '0;
      acc_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
      ff_a_q    <= '0;
      ff_b_q    <= '0;
      ff_cin_q  <= 1'b0;
      ff_idx_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      acc_q     <= acc_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
      ff_a_q    <= ff_a_d;
      ff_b_q    <= ff_b_d;
      ff_cin_q  <= ff_cin_d;
      ff_idx_q  <= ff_idx_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign error    = error_q;
`ifdef ADDER_CHECK_FIRST_FAIL_EN
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_cin   = ff_cin_q;
  assign ff_idx   = ff_idx_q;
`endif

endmodule
